quicksort_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `quicksort` engine among `NUM_REQ` requesters. It selects one pending request and latches that requester's array and index range. It launches the engine with a one-cycle enable, waits for `array_valid` under a timeout, and returns the sorted array with a per-requester done pulse. It sits between the client blocks and the single sort engine and also owns the engine's reset.

---
 rtl/quicksort_arbiter.sv | 163 ++++++++++++++++
 tb/tb_quicksort_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quicksort_arbiter.sv
// Round-robin sequencer that shares one quicksort engine among NUM_REQ requesters.
// Latches the winning job, launches the engine, waits with a timeout and returns the result.
module quicksort_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int ARR_WIDTH = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*ARR_WIDTH*4-1:0] req_array,
   input  logic [NUM_REQ*4-1:0]           req_lo,
   input  logic [NUM_REQ*4-1:0]           req_hi,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             done,
   output logic [ARR_WIDTH*4-1:0]         sorted_out,
   output logic                           err,
   output logic                           timeout,
   output logic                           busy,
   output logic [ARR_WIDTH*4-1:0]         eng_array_in,
   output logic [3:0]                     eng_lo_ind,
   output logic [3:0]                     eng_hi_ind,
   output logic                           eng_enable,
   output logic                           eng_reset,
   input  logic                           eng_array_valid,
   input  logic [ARR_WIDTH*4-1:0]         eng_sorted_array
);

   localparam int              AW        = ARR_WIDTH * 4;
   localparam int              IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [3:0]      MAX_IND   = 4'(ARR_WIDTH - 1);
   localparam logic [7:0]      TO_LIMIT  = 8'(TIMEOUT);
   localparam logic [IW-1:0]   LAST_RST  = IW'(NUM_REQ - 1);
   localparam logic [IW:0]     NUM_REQ_W = (IW + 1)'(NUM_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LAUNCH,
      S_BLANK,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   sel, last, pick;
   logic [IW:0]     cand;
   logic            pick_valid;
   logic [7:0]      wait_cnt;
   logic            wait_expired;
   logic [AW-1:0]   sel_array;
   logic [3:0]      sel_lo, sel_hi;
   logic            range_bad;

   // Rotating priority: first pending request strictly after the last winner.
   // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      pick       = last;
      pick_valid = 1'b0;
      cand       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, last} + (IW + 1)'(i);
         if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
         if (!pick_valid && req[cand[IW-1:0]]) begin
            pick_valid = 1'b1;
            pick       = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      sel_array = req_array[AW-1:0];
      sel_lo    = req_lo[3:0];
      sel_hi    = req_hi[3:0];
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == IW'(i)) begin
            sel_array = req_array[i*AW +: AW];
            sel_lo    = req_lo[i*4 +: 4];
            sel_hi    = req_hi[i*4 +: 4];
         end
      end
   end

   assign range_bad    = (sel_lo > sel_hi) || (sel_hi > MAX_IND);
   assign wait_expired = (wait_cnt == TO_LIMIT);

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (pick_valid) state_nxt = S_LOAD;
         S_LOAD:   state_nxt = range_bad ? S_DONE : S_LAUNCH;
         S_LAUNCH: state_nxt = S_BLANK;
         S_BLANK:  state_nxt = S_WAIT;
         S_WAIT:   if (eng_array_valid || wait_expired) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      grant = '0;
      done  = '0;
      if (state != S_IDLE) grant[sel] = 1'b1;
      if (state == S_DONE) done = grant;
   end

   assign busy       = (state != S_IDLE);
   assign eng_enable = (state == S_LAUNCH);

   // Job fields feed the engine directly, so they are frozen from LOAD onwards.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel          <= '0;
         last         <= LAST_RST;
         eng_array_in <= '0;
         eng_lo_ind   <= '0;
         eng_hi_ind   <= '0;
         wait_cnt     <= '0;
         sorted_out   <= '0;
         err          <= 1'b0;
         timeout      <= 1'b0;
         eng_reset    <= 1'b1;
      end else begin
         eng_reset <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  sel  <= pick;
                  last <= pick;
               end
            end
            S_LOAD: begin
               eng_array_in <= sel_array;
               eng_lo_ind   <= sel_lo;
               eng_hi_ind   <= sel_hi;
               wait_cnt     <= '0;
               err          <= range_bad;
               timeout      <= 1'b0;
               if (range_bad) sorted_out <= sel_array;
            end
            S_WAIT: begin
               if (eng_array_valid) begin
                  sorted_out <= eng_sorted_array;
               end else if (wait_expired) begin
                  timeout    <= 1'b1;
                  sorted_out <= eng_array_in;
                  eng_reset  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_quicksort_arbiter.sv
// Directed bench for quicksort_arbiter driving a behavioural sort engine.
// Expected job results are queued at issue time and compared when done pulses.
module tb_quicksort_arbiter;

   localparam int NUM_REQ   = 2;
   localparam int ARR_WIDTH = 4;
   localparam int TIMEOUT   = 16;
   localparam int AW        = ARR_WIDTH * 4;

   typedef enum int {M_NORMAL, M_NEVER, M_STALE} eng_mode_t;

   typedef struct {
      int          idx;
      logic [15:0] sorted;
      logic        err;
      logic        tmo;
      int          done_cyc;
      int          en_cnt;
      int          en_cyc;
      int          rst_cnt;
   } exp_t;

   logic                           clock = 1'b0;
   logic                           reset_n;
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*AW-1:0]          req_array;
   logic [NUM_REQ*4-1:0]           req_lo;
   logic [NUM_REQ*4-1:0]           req_hi;
   logic [NUM_REQ-1:0]             grant;
   logic [NUM_REQ-1:0]             done;
   logic [AW-1:0]                  sorted_out;
   logic                           err;
   logic                           timeout;
   logic                           busy;
   logic [AW-1:0]                  eng_array_in;
   logic [3:0]                     eng_lo_ind;
   logic [3:0]                     eng_hi_ind;
   logic                           eng_enable;
   logic                           eng_reset;
   logic                           eng_array_valid  = 1'b0;
   logic [AW-1:0]                  eng_sorted_array = '0;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          job_no = 0;
   eng_mode_t   eng_mode = M_NORMAL;
   int          eng_lat  = 1;
   int          eng_t    = 0;
   logic [15:0] eng_res  = '0;
   logic        done_any;

   quicksort_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .ARR_WIDTH (ARR_WIDTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .req              (req),
      .req_array        (req_array),
      .req_lo           (req_lo),
      .req_hi           (req_hi),
      .grant            (grant),
      .done             (done),
      .sorted_out       (sorted_out),
      .err              (err),
      .timeout          (timeout),
      .busy             (busy),
      .eng_array_in     (eng_array_in),
      .eng_lo_ind       (eng_lo_ind),
      .eng_hi_ind       (eng_hi_ind),
      .eng_enable       (eng_enable),
      .eng_reset        (eng_reset),
      .eng_array_valid  (eng_array_valid),
      .eng_sorted_array (eng_sorted_array)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] sort_range(input logic [15:0] a, input int lo, input int hi);
      logic [3:0]  e [4];
      logic [3:0]  t;
      logic [15:0] r;
      for (int k = 0; k < 4; k++) e[k] = a[4*k +: 4];
      for (int i = lo; i <= hi; i++) begin
         for (int j = lo; j < hi; j++) begin
            if (e[j] > e[j+1]) begin
               t      = e[j];
               e[j]   = e[j+1];
               e[j+1] = t;
            end
         end
      end
      for (int k = 0; k < 4; k++) r[4*k +: 4] = e[k];
      return r;
   endfunction

   // Engine model: normal answers eng_lat cycles after start, never stays silent,
   // stale holds a bogus valid around the launch and answers late.
   always @(posedge clock) begin
      eng_array_valid <= 1'b0;
      if (eng_reset) begin
         eng_t <= 0;
      end else if (eng_enable) begin
         eng_t   <= 1;
         eng_res <= sort_range(eng_array_in, int'(eng_lo_ind), int'(eng_hi_ind));
         if (eng_mode == M_STALE) eng_array_valid <= 1'b1;
      end else if (eng_t > 0) begin
         eng_t <= eng_t + 1;
         if ((eng_mode == M_NORMAL && eng_t == eng_lat) || (eng_mode == M_STALE && eng_t == 6)) begin
            eng_array_valid  <= 1'b1;
            eng_sorted_array <= eng_res;
            eng_t            <= 0;
         end
      end else if (eng_mode == M_STALE) begin
         eng_array_valid  <= 1'b1;
         eng_sorted_array <= 16'hEEEE;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int r, input logic [15:0] arr, input logic [3:0] lo, input logic [3:0] hi);
      req_array[r*AW +: AW] = arr;
      req_lo[r*4 +: 4]      = lo;
      req_hi[r*4 +: 4]      = hi;
      req[r]                = 1'b1;
   endtask

   task automatic push_exp(input int r, input logic [15:0] s, input logic e, input logic t,
                           input int dc, input int ec, input int ecyc, input int rc);
      exp_t x;
      x.idx      = r;
      x.sorted   = s;
      x.err      = e;
      x.tmo      = t;
      x.done_cyc = dc;
      x.en_cnt   = ec;
      x.en_cyc   = ecyc;
      x.rst_cnt  = rc;
      sb.push_back(x);
   endtask

   // Counts cycles from the next edge until done; cycle n is the n-th period after that edge.
   task automatic collect(input int mutate_cyc);
      exp_t  x;
      int    n       = 0;
      int    en_cnt  = 0;
      int    en_cyc  = -1;
      int    rst_cnt = 0;
      logic  got     = 1'b0;
      string tg;
      job_no++;
      tg = $sformatf("job%0d", job_no);
      while (!got && n < 40) begin
         @(posedge clock);
         #1;
         n++;
         if (n == mutate_cyc) begin
            req_array = '1;
            req_lo    = '0;
            req_hi    = '1;
         end
         if (eng_enable) begin
            en_cnt++;
            en_cyc = n;
         end
         if (eng_reset) rst_cnt++;
         if (done != '0) got = 1'b1;
      end
      check({tg, "_done_seen"}, 32'(got), 32'd1);
      if (sb.size() > 0) begin
         x = sb.pop_front();
         check({tg, "_done"},      32'(done),       32'(1) << x.idx);
         check({tg, "_grant"},     32'(grant),      32'(1) << x.idx);
         check({tg, "_busy"},      32'(busy),       32'd1);
         check({tg, "_sorted"},    32'(sorted_out), 32'(x.sorted));
         check({tg, "_err"},       32'(err),        32'(x.err));
         check({tg, "_timeout"},   32'(timeout),    32'(x.tmo));
         check({tg, "_eng_reset"}, 32'(eng_reset),  32'(x.tmo));
         check({tg, "_done_cyc"},  32'(n),          32'(x.done_cyc));
         check({tg, "_en_cnt"},    32'(en_cnt),     32'(x.en_cnt));
         check({tg, "_rst_cnt"},   32'(rst_cnt),    32'(x.rst_cnt));
         if (x.en_cnt > 0) check({tg, "_en_cyc"}, 32'(en_cyc), 32'(x.en_cyc));
      end
   endtask

   task automatic release_req();
      @(posedge clock);
      #1;
      check($sformatf("job%0d_done_pulse", job_no), 32'(done), 32'd0);
      check($sformatf("job%0d_eng_reset_low", job_no), 32'(eng_reset), 32'd0);
      req = '0;
   endtask

   initial begin
      reset_n   = 1'b0;
      req       = '0;
      req_array = '0;
      req_lo    = '0;
      req_hi    = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_grant",      32'(grant),      32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_eng_enable", 32'(eng_enable), 32'd0);
      check("rst_eng_reset",  32'(eng_reset),  32'd1);
      check("rst_sorted",     32'(sorted_out), 32'd0);
      check("rst_err_tmo",    32'({err, timeout}), 32'd0);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("rst_eng_reset_drop", 32'(eng_reset), 32'd0);

      // Single sort; request data is scrambled in LAUNCH to prove it was latched in LOAD.
      eng_mode = M_NORMAL;
      eng_lat  = 1;
      issue(0, 16'h3120, 4'd0, 4'd3);
      push_exp(0, 16'h3210, 1'b0, 1'b0, 5, 1, 2, 0);
      collect(2);
      release_req();

      // lo == hi is legal and still goes through the engine.
      issue(1, 16'h0F3C, 4'd2, 4'd2);
      push_exp(1, 16'h0F3C, 1'b0, 1'b0, 5, 1, 2, 0);
      collect(0);
      release_req();

      // Round robin with both requests held: 0,1,0,1, back-to-back jobs one cycle later.
      eng_lat = 2;
      issue(0, 16'h1F07, 4'd0, 4'd3);
      issue(1, 16'h5A29, 4'd1, 4'd3);
      push_exp(0, 16'hF710, 1'b0, 1'b0, 6, 1, 2, 0);
      push_exp(1, 16'hA529, 1'b0, 1'b0, 7, 1, 3, 0);
      push_exp(0, 16'hF710, 1'b0, 1'b0, 7, 1, 3, 0);
      push_exp(1, 16'hA529, 1'b0, 1'b0, 7, 1, 3, 0);
      repeat (4) collect(0);
      release_req();

      // Illegal ranges: lo > hi, then hi beyond the array.
      issue(0, 16'h3120, 4'd2, 4'd1);
      push_exp(0, 16'h3120, 1'b1, 1'b0, 2, 0, -1, 0);
      collect(0);
      release_req();
      issue(1, 16'h8421, 4'd0, 4'd4);
      push_exp(1, 16'h8421, 1'b1, 1'b0, 2, 0, -1, 0);
      collect(0);
      release_req();

      // Timeout: WAIT entered in cycle 4, done TIMEOUT+1 cycles later.
      eng_mode = M_NEVER;
      issue(0, 16'h9876, 4'd0, 4'd3);
      push_exp(0, 16'h9876, 1'b0, 1'b1, 4 + TIMEOUT + 1, 1, 2, 1);
      collect(0);
      release_req();

      // Stale valid through LAUNCH/BLANK must be ignored; real result arrives in cycle 9.
      eng_mode = M_STALE;
      issue(1, 16'h1234, 4'd0, 4'd3);
      push_exp(1, 16'h4321, 1'b0, 1'b0, 10, 1, 2, 0);
      collect(0);
      eng_mode = M_NORMAL;
      release_req();

      // Reset in the middle of WAIT aborts the job; afterwards requester 0 wins again.
      eng_mode = M_NEVER;
      issue(0, 16'h0123, 4'd0, 4'd3);
      repeat (6) begin
         @(posedge clock);
         #1;
      end
      check("rstw_busy_before", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rstw_busy",         32'(busy),         32'd0);
      check("rstw_grant",        32'(grant),        32'd0);
      check("rstw_done",         32'(done),         32'd0);
      check("rstw_eng_enable",   32'(eng_enable),   32'd0);
      check("rstw_eng_reset",    32'(eng_reset),    32'd1);
      check("rstw_sorted",       32'(sorted_out),   32'd0);
      check("rstw_err_tmo",      32'({err, timeout}), 32'd0);
      check("rstw_eng_array_in", 32'(eng_array_in), 32'd0);
      done_any = 1'b0;
      repeat (3) begin
         @(posedge clock);
         #1;
         if (done != '0) done_any = 1'b1;
      end
      check("rstw_no_done",         32'(done_any),  32'd0);
      check("rstw_eng_reset_held",  32'(eng_reset), 32'd1);
      eng_mode = M_NORMAL;
      eng_lat  = 3;
      issue(0, 16'h0123, 4'd0, 4'd3);
      issue(1, 16'hC0DE, 4'd0, 4'd1);
      push_exp(0, 16'h3210, 1'b0, 1'b0, 7, 1, 2, 0);
      push_exp(1, 16'hC0ED, 1'b0, 1'b0, 8, 1, 3, 0);
      #2 reset_n = 1'b1;
      collect(0);
      collect(0);
      release_req();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=no finish expected=finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
